pktc_fifo_ctrl: RTL and testbench
=================================

# pktc_fifo_ctrl

Store-and-forward packet FIFO controller that sequences the packet data memory of the Ethernet MAC tx controller. It owns the memory write/read address pointers and accepts packet beats on a valid/ready stream. It commits each packet only on an error-free `in_eop`, rewinds on error, and replays committed packets on an output stream with sop/eop framing. Packet lengths are kept in a small side FIFO because the data memory carries payload words only.

## Interface
- `DWIDTH`, 32, data word width (matches memory).
- `AWIDTH`, 10, memory address width; capacity = 2^AWIDTH words.
- `LAWIDTH`, 4, length FIFO address width; up to 2^LAWIDTH committed packets.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid` / `in_ready`  in / out  1  input beat handshake.
- `in_data`  in  DWIDTH  payload word.
- `in_sop`, `in_eop`, `in_err`  in  1  framing; `in_err` is sampled only with `in_eop`.
- `out_valid` / `out_ready`  out / in  1  output beat handshake.
- `out_data`  out  DWIDTH  equals `mem_rdata`.
- `out_sop`, `out_eop`  out  1  output framing.
- `mem_waddr`, `mem_raddr`  out  AWIDTH  memory addresses.
- `mem_wdata`  out  DWIDTH  write data.
- `mem_write`  out  1  write strobe; memory writes on the `clk` edge.
- `mem_rdata`  in  DWIDTH  combinational read of `mem_raddr`.
- `pkt_count`  out  LAWIDTH+1  committed, not-yet-fully-read packets.
- `drop_count`  out  16  dropped packets; saturates at 16'hFFFF.
- `free_words`  out  AWIDTH+1  free memory words.

## Operation
- Pointers `wr_ptr`, `wr_commit`, `rd_ptr` are AWIDTH+1 bits and wrap modulo 2^(AWIDTH+1).
- `free_words = 2^AWIDTH - (wr_ptr - rd_ptr)`.
- `mem_waddr = wr_ptr[AWIDTH-1:0]`; `mem_raddr = rd_ptr[AWIDTH-1:0]`; `mem_wdata = in_data`.
- `mem_write = in_valid & in_ready & (state != W_DROP) & (state == W_PKT | in_sop)`.
- Write FSM has three states.
  - W_IDLE: a beat without `in_sop` is discarded and not counted. A beat with `in_sop` is written, `wr_ptr`++ and `len`=1, then the FSM goes to W_PKT. If that beat also has `in_eop`, the packet is committed instead and the FSM stays in W_IDLE.
  - W_PKT: each beat is written, `wr_ptr`++ and `len`++.
  - W_PKT, `in_sop` mid-packet: rewind `wr_ptr` to `wr_commit` and increment `drop_count`. The beat then starts a new packet with `len`=1.
  - W_PKT, `in_eop & ~in_err`: commit. `wr_commit <= wr_ptr+1`, push `len+1` into the length FIFO, go to W_IDLE.
  - W_PKT, `in_eop & in_err`: rewind, `drop_count`++, go to W_IDLE.
  - W_PKT, `free_words==0` with `wr_commit==rd_ptr` (packet larger than memory): rewind, `drop_count`++, go to W_DROP.
  - W_DROP: `in_ready`=1 and beats are discarded. The `in_eop` beat returns the FSM to W_IDLE.
- `in_ready` in W_IDLE/W_PKT is `(free_words != 0) & ~lfifo_full`.
- Read FSM has two states.
  - R_IDLE: if the length FIFO is non-empty, pop its head into `rem`, set `first`=1, go to R_PKT.
  - R_PKT: `out_valid`=1, `out_sop=first`, `out_eop=(rem==1)`.
  - On each transfer: `rd_ptr`++, `rem`--, `first`=0.
  - The eop transfer returns the FSM to R_IDLE.
- `pkt_count`: +1 on commit, -1 on eop transfer; no change when both occur in the same cycle.

## Timing
- Reset clears all pointers, `len`, `rem`, and both counters, and sets both FSMs to IDLE.
- Reset output values:
  - `out_valid`, `out_sop`, `out_eop`, `mem_write` = 0.
  - `in_ready` = 1.
  - `free_words` = 2^AWIDTH; `pkt_count` = 0.
- Reset mid-packet discards all stored data.
- Commit on the eop edge at cycle N: the length FIFO is non-empty at N+1, and `out_valid` first rises at N+2.
- There is one bubble cycle between back-to-back output packets (R_IDLE).
- Read frees space one cycle after the transfer, since `free_words` uses the registered `rd_ptr`.
- Rewind and read in the same cycle are independent. A rewind never moves `wr_ptr` below `rd_ptr`.
- `out_valid` must not drop while `out_ready`=0. `out_data` is held because `rd_ptr` is held.

## Structure
- Package `pktc_pkg` holds:
  - write state enum (W_IDLE, W_PKT, W_DROP) and read state enum (R_IDLE, R_PKT);
  - pointer typedef sized AWIDTH+1;
  - the drop counter width constant.
- Sub-module `pktc_len_fifo`: synchronous FIFO, width AWIDTH+1, depth 2^LAWIDTH, with full/empty outputs and registered pointers.

## Test plan
- Single 4-word packet 0x11..0x44 with `out_ready`=1 -> the same words appear at N+2..N+5, with `out_sop` on 0x11 and `out_eop` on 0x44; `pkt_count` goes 1 then 0.
- A 3-word packet with `in_err` on eop, followed by a good 2-word packet -> only the 2-word packet is output, `drop_count`=1, and `wr_ptr` equals 2.
- Fill with AWIDTH=4 (16 words) and `out_ready`=0 -> `in_ready` falls when `free_words`=0. Raising `out_ready` drains the data; `in_ready` returns one cycle after the first transfer.
- A 20-word packet into a 16-word memory -> W_DROP, `drop_count`=1, nothing output, and `free_words` returns to 16.
- `rst` pulse mid-packet and mid-read -> all outputs return to their reset values immediately; a following packet passes normally.
- 17 one-word packets with LAWIDTH=4 and `out_ready`=0 -> `in_ready`=0 after the 16th commit and `pkt_count`=16.

Source files
------------

// File: rtl/pktc_pkg.sv
// rtl/pktc_pkg.sv - shared types and constants for the packet FIFO controller
package pktc_pkg;

    localparam int PKTC_AWIDTH = 10;
    localparam int DROP_W      = 16;

    typedef logic [PKTC_AWIDTH:0] pktc_ptr_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PKT,
        W_DROP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_PKT
    } rstate_t;

endpackage

// File: rtl/pktc_len_fifo.sv
// rtl/pktc_len_fifo.sv - first-word-fall-through FIFO of committed packet lengths
module pktc_len_fifo #(
    parameter int WIDTH = 11,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) begin
                wp <= wp + 1'b1;
            end
            if (pop && !empty) begin
                rp <= rp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wp[AW-1:0]] <= din;
        end
    end

    assign dout  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/pktc_fifo_ctrl.sv
// rtl/pktc_fifo_ctrl.sv - store-and-forward packet FIFO controller for the MAC tx data memory
module pktc_fifo_ctrl
    import pktc_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 10,
    parameter int LAWIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWIDTH-1:0]  in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic               in_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DWIDTH-1:0]  out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic [AWIDTH-1:0]  mem_waddr,
    output logic [AWIDTH-1:0]  mem_raddr,
    output logic [DWIDTH-1:0]  mem_wdata,
    output logic               mem_write,
    input  logic [DWIDTH-1:0]  mem_rdata,
    output logic [LAWIDTH:0]   pkt_count,
    output logic [DROP_W-1:0]  drop_count,
    output logic [AWIDTH:0]    free_words
);

    localparam logic [AWIDTH:0] CAP  = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] PONE = {{AWIDTH{1'b0}}, 1'b1};

    wstate_t wstate, wstate_n;
    rstate_t rstate, rstate_n;

    logic [AWIDTH:0]   wr_ptr, wr_ptr_n;
    logic [AWIDTH:0]   wr_commit, wr_commit_n;
    logic [AWIDTH:0]   len, len_n;
    logic [AWIDTH:0]   rd_ptr;
    logic [AWIDTH:0]   rem;
    logic              first;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W:0]   drop_sum;
    logic [1:0]        drops;
    logic [LAWIDTH:0]  pkt_cnt;

    logic              fire;
    logic              restart;
    logic              overflow;
    logic              start;
    logic              push;
    logic [AWIDTH:0]   push_len;
    logic              pop;
    logic              xfer;
    logic              eop_xfer;
    logic              lf_full;
    logic              lf_empty;
    logic [AWIDTH:0]   lf_dout;

    assign free_words = CAP - (wr_ptr - rd_ptr);
    assign in_ready   = (wstate == W_DROP) | ((free_words != '0) & ~lf_full);
    assign fire       = in_valid & in_ready;
    assign mem_write  = fire & (wstate != W_DROP) & ((wstate == W_PKT) | in_sop);
    assign restart    = (wstate == W_PKT) & in_sop;
    assign overflow   = (free_words == '0) & (wr_commit == rd_ptr);

    // A mid-packet sop abandons the partial packet, so its word lands at the commit point.
    assign mem_waddr  = restart ? wr_commit[AWIDTH-1:0] : wr_ptr[AWIDTH-1:0];
    assign mem_raddr  = rd_ptr[AWIDTH-1:0];
    assign mem_wdata  = in_data;
    assign out_data   = mem_rdata;
    assign pkt_count  = pkt_cnt;
    assign drop_count = drop_cnt;

    always_comb begin
        wstate_n    = wstate;
        wr_ptr_n    = wr_ptr;
        wr_commit_n = wr_commit;
        len_n       = len;
        drops       = 2'd0;
        start       = 1'b0;
        push        = 1'b0;
        push_len    = len + 1'b1;
        case (wstate)
            W_IDLE: begin
                if (fire && in_sop) begin
                    start = 1'b1;
                end
            end
            W_PKT: begin
                if (overflow) begin
                    wr_ptr_n = wr_commit;
                    drops    = 2'd1;
                    wstate_n = W_DROP;
                end else if (fire) begin
                    if (in_sop) begin
                        drops = 2'd1;
                        start = 1'b1;
                    end else if (in_eop && in_err) begin
                        wr_ptr_n = wr_commit;
                        drops    = 2'd1;
                        wstate_n = W_IDLE;
                    end else if (in_eop) begin
                        wr_ptr_n    = wr_ptr + 1'b1;
                        wr_commit_n = wr_ptr + 1'b1;
                        push        = 1'b1;
                        wstate_n    = W_IDLE;
                    end else begin
                        wr_ptr_n = wr_ptr + 1'b1;
                        len_n    = len + 1'b1;
                    end
                end
            end
            W_DROP: begin
                if (fire && in_eop) begin
                    wstate_n = W_IDLE;
                end
            end
            default: wstate_n = W_IDLE;
        endcase

        // Every packet starts at the commit point (equal to wr_ptr whenever idle).
        if (start) begin
            if (in_eop && in_err) begin
                wr_ptr_n = wr_commit;
                drops    = drops + 2'd1;
                wstate_n = W_IDLE;
            end else if (in_eop) begin
                wr_ptr_n    = wr_commit + 1'b1;
                wr_commit_n = wr_commit + 1'b1;
                push        = 1'b1;
                push_len    = PONE;
                wstate_n    = W_IDLE;
            end else begin
                wr_ptr_n = wr_commit + 1'b1;
                len_n    = PONE;
                wstate_n = W_PKT;
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + {{(DROP_W - 1){1'b0}}, drops};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate    <= W_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            len       <= '0;
            drop_cnt  <= '0;
        end else begin
            wstate    <= wstate_n;
            wr_ptr    <= wr_ptr_n;
            wr_commit <= wr_commit_n;
            len       <= len_n;
            drop_cnt  <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
        end
    end

    always_comb begin
        rstate_n  = rstate;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        xfer      = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (!lf_empty) begin
                    pop      = 1'b1;
                    rstate_n = R_PKT;
                end
            end
            R_PKT: begin
                out_valid = 1'b1;
                out_sop   = first;
                out_eop   = (rem == PONE);
                xfer      = out_ready;
                if (out_ready && (rem == PONE)) begin
                    rstate_n = R_IDLE;
                end
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    assign eop_xfer = xfer & out_eop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate  <= R_IDLE;
            rd_ptr  <= '0;
            rem     <= '0;
            first   <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            rstate <= rstate_n;
            if (pop) begin
                rem   <= lf_dout;
                first <= 1'b1;
            end else if (xfer) begin
                rem   <= rem - 1'b1;
                first <= 1'b0;
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, eop_xfer})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    pktc_len_fifo #(
        .WIDTH (AWIDTH + 1),
        .AW    (LAWIDTH)
    ) u_len_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_len),
        .pop   (pop),
        .dout  (lf_dout),
        .full  (lf_full),
        .empty (lf_empty)
    );

endmodule

// File: tb/tb_pktc_fifo_ctrl.sv
// tb/tb_pktc_fifo_ctrl.sv - self-checking bench for pktc_fifo_ctrl with a 16-word memory
module tb_pktc_fifo_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int LAW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, out_sop, out_eop, mem_write;
    logic [DW-1:0] out_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [LAW:0]  pkt_count;
    logic [15:0]   drop_count;
    logic [AW:0]   free_words;

    pktc_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .LAWIDTH(LAW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata),
        .pkt_count(pkt_count), .drop_count(drop_count), .free_words(free_words)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    always @(posedge clk) if (mem_write) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    int checks = 0;
    int errors = 0;
    int model_drops = 0;
    bit rnd_ready = 1'b0;

    logic [33:0] got[$];
    logic [33:0] exp_q[$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    typedef struct {
        logic [3:0]  in_f;   // {valid, sop, eop, err}
        logic [31:0] d;
        logic        ordy;
        logic [4:0]  exp_f;  // {out_valid, out_sop, out_eop, in_ready, mem_write}
        logic [31:0] e_od;
        logic [4:0]  e_pc;
        logic [4:0]  e_fw;
    } vec_t;
    vec_t vt[11];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(string what);
        errors++;
        $display("FAIL timeout_%s actual=stalled required=progress", what);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench stopped");
    endtask

    // Output monitor: collects accepted beats and checks valid/data stay stable under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) got.push_back({out_sop, out_eop, out_data});
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic send_beat(logic [31:0] d, logic s, logic e, logic er);
        int t;
        t = 0;
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_err = er;
        @(negedge clk);
        while (!in_ready) begin
            t++;
            if (t > 4000) timeout("in_ready");
            step();
            @(negedge clk);
        end
        step();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
    endtask

    // Model: a packet reaches the output only if it is complete, error-free and fits the memory.
    task automatic send_pkt(int id, int len, bit err, int trunc, bit gaps);
        int n;
        logic [31:0] d;
        n = (trunc > 0) ? trunc : len;
        for (int b = 0; b < n; b++) begin
            d = (32'(id) << 16) | 32'(b);
            send_beat(d, b == 0, (trunc == 0) && (b == len - 1), err && (trunc == 0) && (b == len - 1));
            if (gaps && $urandom_range(0, 3) == 0) step();
        end
        if (trunc == 0 && !err && len <= 16) begin
            for (int b = 0; b < len; b++) begin
                d = (32'(id) << 16) | 32'(b);
                exp_q.push_back({(b == 0), (b == len - 1), d});
            end
        end else begin
            model_drops++;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while (!(pkt_count == 0 && !out_valid && t > 2)) begin
            t++;
            if (t > 4000) timeout("drain");
            step();
            @(negedge clk);
        end
        step();
    endtask

    task automatic compare_stream(string tag);
        int n;
        check({tag, "_beats"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    endtask

    initial begin
        vt[0]  = '{4'b0000, 32'h00, 1'b1, 5'b00010, 32'h00, 5'd0, 5'd16};
        vt[1]  = '{4'b1100, 32'h11, 1'b1, 5'b00011, 32'h00, 5'd0, 5'd16};
        vt[2]  = '{4'b1000, 32'h22, 1'b1, 5'b00011, 32'h00, 5'd0, 5'd15};
        vt[3]  = '{4'b1000, 32'h33, 1'b1, 5'b00011, 32'h00, 5'd0, 5'd14};
        vt[4]  = '{4'b1010, 32'h44, 1'b1, 5'b00011, 32'h00, 5'd0, 5'd13};
        vt[5]  = '{4'b0000, 32'h00, 1'b1, 5'b00010, 32'h00, 5'd1, 5'd12};
        vt[6]  = '{4'b0000, 32'h00, 1'b1, 5'b11010, 32'h11, 5'd1, 5'd12};
        vt[7]  = '{4'b0000, 32'h00, 1'b1, 5'b10010, 32'h22, 5'd1, 5'd13};
        vt[8]  = '{4'b0000, 32'h00, 1'b1, 5'b10010, 32'h33, 5'd1, 5'd14};
        vt[9]  = '{4'b0000, 32'h00, 1'b1, 5'b10110, 32'h44, 5'd1, 5'd15};
        vt[10] = '{4'b0000, 32'h00, 1'b1, 5'b00010, 32'h00, 5'd0, 5'd16};

        // Reset values and the single 4-word packet, cycle by cycle.
        do_reset();
        @(negedge clk);
        check("rst_flags", 64'({out_valid, out_sop, out_eop, mem_write, in_ready}), 64'(5'b00001));
        check("rst_free", 64'(free_words), 64'(16));
        check("rst_pkt", 64'(pkt_count), 64'(0));
        check("rst_drop", 64'(drop_count), 64'(0));
        step();
        for (int i = 0; i < 11; i++) begin
            {in_valid, in_sop, in_eop, in_err} = vt[i].in_f;
            in_data = vt[i].d;
            out_ready = vt[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_flags", i), 64'({out_valid, out_sop, out_eop, in_ready, mem_write}), 64'(vt[i].exp_f));
            if (vt[i].exp_f[4]) check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vt[i].e_od));
            check($sformatf("vec%0d_pkt", i), 64'(pkt_count), 64'(vt[i].e_pc));
            check($sformatf("vec%0d_free", i), 64'(free_words), 64'(vt[i].e_fw));
            step();
        end
        in_valid = 1'b0;

        // Errored packet followed by a good one.
        do_reset();
        send_pkt(1, 3, 1'b1, 0, 1'b0);
        send_pkt(2, 2, 1'b0, 0, 1'b0);
        drain();
        compare_stream("err");
        @(negedge clk);
        check("err_drop", 64'(drop_count), 64'(1));
        check("err_wptr", 64'(mem_waddr), 64'(2));
        check("err_free", 64'(free_words), 64'(16));
        step();

        // Fill the memory with the reader stalled, then release it.
        do_reset();
        out_ready = 1'b0;
        send_pkt(3, 10, 1'b0, 0, 1'b0);
        send_pkt(4, 6, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("fill_ready_full", 64'(in_ready), 64'(0));
        check("fill_free_zero", 64'(free_words), 64'(0));
        check("fill_valid", 64'(out_valid), 64'(1));
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("fill_ready_at_xfer", 64'(in_ready), 64'(0));
        step();
        @(negedge clk);
        check("fill_ready_after", 64'(in_ready), 64'(1));
        step();
        send_pkt(5, 3, 1'b0, 0, 1'b0);
        drain();
        compare_stream("fill");

        // Packet larger than the memory.
        do_reset();
        send_pkt(6, 20, 1'b0, 0, 1'b0);
        repeat (3) step();
        @(negedge clk);
        check("big_drop", 64'(drop_count), 64'(1));
        check("big_free", 64'(free_words), 64'(16));
        check("big_out", 64'(got.size()), 64'(0));
        step();
        send_pkt(7, 2, 1'b0, 0, 1'b0);
        drain();
        compare_stream("big");

        // Asynchronous reset mid-read and mid-write.
        do_reset();
        out_ready = 1'b0;
        send_pkt(8, 3, 1'b0, 0, 1'b0);
        send_beat(32'h0009_0000, 1'b1, 1'b0, 1'b0);
        send_beat(32'h0009_0001, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_flags", 64'({out_valid, out_sop, out_eop, mem_write, in_ready}), 64'(5'b00001));
        check("arst_free", 64'(free_words), 64'(16));
        check("arst_pkt", 64'(pkt_count), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        exp_q.delete();
        out_ready = 1'b1;
        send_pkt(10, 4, 1'b0, 0, 1'b0);
        drain();
        compare_stream("arst");

        // Sixteen one-word packets with the reader stalled, then a seventeenth.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) send_pkt(20 + k, 1, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("p16_ready", 64'(in_ready), 64'(0));
        check("p16_pkt", 64'(pkt_count), 64'(16));
        step();
        out_ready = 1'b1;
        send_pkt(36, 1, 1'b0, 0, 1'b0);
        drain();
        compare_stream("p17");

        // Randomized traffic against the packet-level model.
        do_reset();
        model_drops = 0;
        rnd_ready = 1'b1;
        begin
            bit prev_trunc;
            int len, trunc;
            bit err;
            prev_trunc = 1'b0;
            for (int p = 0; p < 60; p++) begin
                len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 10));
                err = (len > 1) && ($urandom_range(0, 9) == 0);
                trunc = 0;
                if (p < 59 && len > 1 && len <= 16 && !err && $urandom_range(0, 11) == 0)
                    trunc = int'($urandom_range(1, len - 1));
                if (!prev_trunc && $urandom_range(0, 7) == 0)
                    send_beat($urandom, 1'b0, 1'b0, 1'b0);
                send_pkt(100 + p, len, err, trunc, 1'b1);
                prev_trunc = (trunc > 0);
            end
        end
        drain();
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        compare_stream("rnd");
        @(negedge clk);
        check("rnd_drop", 64'(drop_count), 64'(model_drops));
        check("rnd_free", 64'(free_words), 64'(16));
        check("rnd_pkt", 64'(pkt_count), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
